// File: rtl/div_req_ctrl.sv
// div_req_ctrl: valid/ready front end and result FIFO for a fixed-latency 64/32 divider.
// Define DIV_STATS_EN to add the stat_ops/stat_dz pop counters.
module div_req_ctrl #(
  parameter int DIV_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_x,
  input  logic [31:0]      in_d,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      div_x,
  output logic [31:0]      div_d,
  output logic             div_en,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             out_ovf
`ifdef DIV_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_dz
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             ovf;
    logic [31:0]      xlo;
  } meta_t;
  typedef struct packed {
    logic [31:0]      q;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             ovf;
  } ent_t;
  logic [DIV_LAT-1:0] vld_q, vld_d;
  meta_t              meta_q [DIV_LAT];
  meta_t              meta_d [DIV_LAT];
  ent_t               mem_q [FIFO_DEPTH];
  ent_t               ent_d, head;
  meta_t              tail;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d, inflight;
  logic               fire, push, pop;
  assign div_x  = in_x;
  assign div_d  = in_d;
  assign div_en = ~rstn;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DIV_LAT; i++) inflight = inflight + CW'(vld_q[i]);
  end
  // Credit counts every op not yet popped, so the uncontrollable divider never overruns the FIFO.
  assign in_ready  = ~rstn & ((cnt_q + inflight) < CW'(FIFO_DEPTH));
  assign fire      = in_valid & in_ready;
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid & out_ready;
  assign tail      = meta_q[DIV_LAT-1];
  assign push      = vld_q[DIV_LAT-1];
  assign head      = mem_q[rd_ptr_q];
  always_comb begin
    vld_d[0]  = fire;
    meta_d[0] = '{tag: in_tag, dz: in_d == '0, ovf: (in_d != '0) && (in_x[63:32] >= in_d), xlo: in_x[31:0]};
    for (int i = 1; i < DIV_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      meta_d[i] = meta_q[i-1];
    end
  end
  always_comb begin
    ent_d    = '{q: tail.dz ? 32'hFFFF_FFFF : div_q, r: tail.dz ? tail.xlo : div_r,
                 tag: tail.tag, dz: tail.dz, ovf: tail.ovf};
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end
  assign out_q   = out_valid ? head.q   : '0;
  assign out_r   = out_valid ? head.r   : '0;
  assign out_tag = out_valid ? head.tag : '0;
  assign out_dz  = out_valid & head.dz;
  assign out_ovf = out_valid & head.ovf;
  always_ff @(posedge clk) begin
    if (rstn) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    meta_q <= meta_d;
    if (push) mem_q[wr_ptr_q] <= ent_d;
  end
`ifdef DIV_STATS_EN
  logic [31:0] ops_q, ops_d;
  logic [15:0] sdz_q, sdz_d;
  always_comb begin
    ops_d = ops_q + 32'(pop);
    sdz_d = sdz_q + 16'(pop & head.dz);
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      ops_q <= '0;
      sdz_q <= '0;
    end else begin
      ops_q <= ops_d;
      sdz_q <= sdz_d;
    end
  end
  assign stat_ops = ops_q;
  assign stat_dz  = sdz_q;
`endif
endmodule

// File: tb/tb_div_req_ctrl.sv
// tb_div_req_ctrl: directed vectors, corner sequences and random traffic against a queue model.
module tb_div_req_ctrl;
  logic        clk = 0, rstn = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, div_en, out_dz, out_ovf;
  logic [63:0] in_x = 0, div_x;
  logic [31:0] in_d = 0, div_d, div_q, div_r, out_q, out_r;
  logic [3:0]  in_tag = 0, out_tag;
`ifdef DIV_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_dz;
`endif
  always #5 clk = ~clk;

  div_req_ctrl dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_d(in_d),
    .in_tag(in_tag), .div_x(div_x), .div_d(div_d), .div_en(div_en), .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r), .out_tag(out_tag),
    .out_dz(out_dz), .out_ovf(out_ovf)
`ifdef DIV_STATS_EN
    , .stat_ops(stat_ops), .stat_dz(stat_dz)
`endif
  );

  // Stand-in 2-stage divider; garbage on d==0 so the controller must substitute its own values.
  logic [63:0] dx0, dx1;
  logic [31:0] dd0, dd1;
  always @(posedge clk) if (div_en) begin
    dx0 <= div_x; dd0 <= div_d; dx1 <= dx0; dd1 <= dd0;
  end
  assign div_q = (dd1 == 0) ? 32'hDEAD_BEEF : 32'(dx1 / {32'd0, dd1});
  assign div_r = (dd1 == 0) ? 32'hBAAD_F00D : 32'(dx1 % {32'd0, dd1});

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] q, r;
    logic [3:0]  tag;
    logic        dz, ovf;
    int          vis;
  } exp_t;

  function automatic exp_t model(input logic [63:0] x, input logic [31:0] d, input logic [3:0] tag);
    exp_t e;
    logic [63:0] qq, rr;
    e.tag = tag;
    e.dz  = (d == 0);
    e.ovf = !e.dz && (x[63:32] >= d);
    if (e.dz) begin
      qq = 64'hFFFF_FFFF; rr = {32'd0, x[31:0]};
    end else begin
      qq = x / {32'd0, d}; rr = x % {32'd0, d};
    end
    e.q = qq[31:0]; e.r = rr[31:0]; e.vis = 0;
    return e;
  endfunction

  // Model: every accepted op is outstanding until popped; it becomes visible 3 edges after acceptance.
  exp_t        sb[$];
  exp_t        ne;
  bit          armed = 0, exp_rdy, exp_ov;
  logic [31:0] pops;
  logic [15:0] dzp;
  always @(negedge clk) begin
    exp_rdy = 0; exp_ov = 0;
    if (armed) begin
      exp_rdy = !rstn && (sb.size() < 4);
      if (sb.size() > 0) exp_ov = !rstn && (sb[0].vis <= cyc);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("div_en", 64'(div_en), 64'(!rstn));
      chk("div_xd", {div_x[31:0], div_d}, {in_x[31:0], in_d});
      if (exp_ov) begin
        chk("out_q", 64'(out_q), 64'(sb[0].q));
        chk("out_r", 64'(out_r), 64'(sb[0].r));
        chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
        chk("out_dz_ovf", 64'({out_dz, out_ovf}), 64'({sb[0].dz, sb[0].ovf}));
      end else begin
        chk("idle_qr", {out_q, out_r}, 64'd0);
        chk("idle_meta", 64'({out_tag, out_dz, out_ovf}), 64'd0);
      end
`ifdef DIV_STATS_EN
      chk("stat_ops", 64'(stat_ops), 64'(pops));
      chk("stat_dz", 64'(stat_dz), 64'(dzp));
`endif
    end
    if (rstn) begin
      sb.delete(); pops = 0; dzp = 0; armed = 1;
    end else if (armed) begin
      if (exp_ov && out_ready) begin
        dzp = dzp + 16'(sb[0].dz); pops = pops + 1; void'(sb.pop_front());
      end
      if (in_valid && exp_rdy) begin
        ne = model(in_x, in_d, in_tag); ne.vis = cyc + 3; sb.push_back(ne);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_op();
    int m;
    m = $urandom_range(0, 3);
    in_d = (m == 0) ? 32'd0 : (m == 1) ? 32'($urandom_range(1, 255)) : ($urandom | 32'h1);
    in_x = {(m == 1) ? 32'($urandom) : 32'($urandom >> 1), 32'($urandom)};
  endtask

  task automatic run_one(input logic [63:0] x, input logic [31:0] d, input logic [3:0] tag,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz, input logic eovf);
    bit seen;
    seen = 0;
    tick();
    in_valid = 1; in_x = x; in_d = d; in_tag = tag;
    tick();
    in_valid = 0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        chk("vec_latency", 64'(n), 64'd3);
        chk("vec_q", 64'(out_q), 64'(eq));
        chk("vec_r", 64'(out_r), 64'(er));
        chk("vec_tag", 64'(out_tag), 64'(tag));
        chk("vec_dz_ovf", 64'({out_dz, out_ovf}), 64'({edz, eovf}));
      end
    end
    if (!seen) chk("vec_timeout", 64'(out_valid), 64'd1);
  endtask

  typedef struct {
    logic [63:0] x;
    logic [31:0] d;
    logic [3:0]  tag;
    logic [31:0] q, r;
    logic        dz, ovf;
  } vec_t;
  vec_t tbl[8];

  int acc, bad, run, maxrun;
  logic [3:0] got[$];

  initial begin
    tbl[0] = '{64'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0};
    tbl[1] = '{64'h0000_0005_0000_0000, 32'd0, 4'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0};
    tbl[2] = '{64'h0000_0010_0000_0000, 32'd16, 4'd6, 32'd0, 32'd0, 1'b0, 1'b1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'd1, 32'd0, 1'b0, 1'b1};
    tbl[4] = '{64'h0000_0000_FFFF_FFFF, 32'd1, 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0};
    tbl[5] = '{64'h0000_0001_2345_6789, 32'd0, 4'd10, 32'hFFFF_FFFF, 32'h2345_6789, 1'b1, 1'b0};
    tbl[6] = '{64'd1000, 32'd1000, 4'd11, 32'd1, 32'd0, 1'b0, 1'b0};
    tbl[7] = '{64'h0000_0006_0000_0003, 32'd7, 4'd12, 32'd3681400539, 32'd6, 1'b0, 1'b0};
    repeat (3) tick();
    rstn = 0;
    foreach (tbl[i]) run_one(tbl[i].x, tbl[i].d, tbl[i].tag, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf);

    // Backpressure: credit must stop at four outstanding ops.
    tick();
    out_ready = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1; in_tag = 4'(acc); rand_op();
      #2 if (in_ready) acc++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    out_ready = 1;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      in_valid = 1; in_tag = 4'(acc); rand_op();
      #2 if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    chk("bp_total", 64'(acc), 64'd8);
    repeat (20) tick();

    // Throughput: ten back-to-back accepts, ten consecutive results.
    acc = 0; run = 0; maxrun = 0; got.delete();
    fork
      begin
        for (int c = 0; c < 10; c++) begin
          in_valid = 1; in_tag = 4'(c); rand_op();
          #2 if (in_ready) acc++;
          tick();
        end
        in_valid = 0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid) begin
            got.push_back(out_tag); run++;
            if (run > maxrun) maxrun = run;
          end else run = 0;
        end
      end
    join
    chk("tp_accepts", 64'(acc), 64'd10);
    chk("tp_results", 64'(got.size()), 64'd10);
    chk("tp_consecutive", 64'(maxrun), 64'd10);
    foreach (got[i]) chk("tp_tag_order", 64'(got[i]), 64'(i));

    // Reset with two ops in flight: neither may surface.
    tick();
    in_valid = 1; in_tag = 4'd1; in_x = 64'd50; in_d = 32'd5;
    tick();
    in_tag = 4'd2;
    tick();
    in_valid = 0; rstn = 1;
    tick();
    rstn = 0; bad = 0;
`ifdef DIV_STATS_EN
    @(negedge clk);
    chk("stat_ops_after_rst", 64'(stat_ops), 64'd0);
    chk("stat_dz_after_rst", 64'(stat_dz), 64'd0);
`endif
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("rst_discard", 64'(bad), 64'd0);
    run_one(64'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0);

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 400; c++) begin
      tick();
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      in_tag = 4'($urandom);
      rand_op();
      rstn = ($urandom_range(0, 149) == 0);
    end
    tick();
    in_valid = 0; out_ready = 1; rstn = 0;
    repeat (20) tick();
    @(negedge clk);
    chk("final_idle", 64'(out_valid), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
